// File: rtl/sprite_overlay_ctrl.sv
// sprite_overlay_ctrl: ROM-backed sprite compositor with tear-free moves; blinking built in when SPRITE_BLINK_EN is defined
module sprite_overlay_ctrl #(
  parameter int W = 150,
  parameter int H = 11,
  parameter int COL_W = 8,
  parameter int ROW_W = 4,
  parameter int ROM_LAT = 1,
  parameter logic [11:0] KEY_COLOR = 12'hFFF,
  parameter logic [9:0] X_INIT = 10'd375,
  parameter logic [9:0] Y_INIT = 10'd145,
  parameter int SCALE_SHIFT = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic bright,
  input  logic en,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic pos_load,
  input  logic blink_en,
  input  logic [11:0] background,
  output logic [ROW_W-1:0] rom_row,
  output logic [COL_W-1:0] rom_col,
  input  logic [11:0] rom_color,
  output logic pos_pending,
  output logic [11:0] rgb
);
  localparam logic [10:0] WS = 11'(W << SCALE_SHIFT);
  localparam logic [10:0] HS = 11'(H << SCALE_SHIFT);
  logic fs, hit, visible, hit_q, bright_q;
  logic [9:0] cur_x, cur_y, stg_x, stg_y;
  logic [10:0] dx, dy;
  logic [11:0] bg_q;
  logic [13:0] stage [ROM_LAT];
  assign fs = hCount == 10'd0 && vCount == 10'd0;
  assign dx = {1'b0, hCount} - {1'b0, cur_x};
  assign dy = {1'b0, vCount} - {1'b0, cur_y};
  assign hit = en && visible && !dx[10] && !dy[10] && dx < WS && dy < HS;
  assign rom_col = hit ? COL_W'(dx >> SCALE_SHIFT) : '0;
  assign rom_row = hit ? ROW_W'(dy >> SCALE_SHIFT) : '0;
  // Stage a requested position and commit it only at frame start
  always_ff @(posedge clk)
    if (rst) begin
      cur_x <= X_INIT;
      cur_y <= Y_INIT;
      stg_x <= X_INIT;
      stg_y <= Y_INIT;
      pos_pending <= 1'b0;
    end else begin
      if (pos_load) begin
        stg_x <= pos_x;
        stg_y <= pos_y;
      end
      if (fs && pos_pending) begin
        cur_x <= stg_x;
        cur_y <= stg_y;
      end
      pos_pending <= pos_load || (pos_pending && !fs);
    end
  // Delay hit/bright/background to line up with the ROM read latency
  always_ff @(posedge clk) begin
    stage[0] <= rst ? '0 : {hit, bright, background};
    for (int i = 1; i < ROM_LAT; i++) stage[i] <= rst ? '0 : stage[i-1];
  end
  assign {hit_q, bright_q, bg_q} = stage[ROM_LAT-1];
  assign rgb = !bright_q ? 12'h000 : (hit_q && rom_color != KEY_COLOR) ? rom_color : bg_q;
`ifdef SPRITE_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);
  logic [FW-1:0] fcnt;
  // Count frames and toggle visibility every BLINK_FRAMES frame starts
  always_ff @(posedge clk)
    if (rst || !blink_en) begin
      fcnt <= '0;
      visible <= 1'b1;
    end else if (fs) begin
      fcnt <= (fcnt == FLAST) ? '0 : fcnt + 1'b1;
      visible <= (fcnt == FLAST) ? !visible : visible;
    end
`else
  logic unused_blink;
  assign visible = 1'b1;
  assign unused_blink = blink_en & (BLINK_FRAMES > 0);
`endif
endmodule

// File: tb/tb_sprite_overlay_ctrl.sv
// tb_sprite_overlay_ctrl: randomized and directed checks of the sprite overlay against a pixel-level reference model
module tb_sprite_overlay_ctrl;
  localparam int LAT = 3;
  localparam int SS = 1;
  localparam int BF = 2;
  localparam int SW = 150;
  localparam int SH = 11;
  logic clk, rst, bright, en, pos_load, blink_en, pos_pending;
  logic [9:0] hCount, vCount, pos_x, pos_y;
  logic [11:0] background, rom_color, rgb;
  logic [3:0] rom_row;
  logic [7:0] rom_col;
  logic [11:0] rom [16][256];
  logic [11:0] rp [LAT];
  logic [11:0] q [$];
  int checks = 0, errors = 0;
  int cx, cy, sx, sy, nfr;
  bit pend, ready = 0;

  sprite_overlay_ctrl #(.W(SW), .H(SH), .ROM_LAT(LAT), .SCALE_SHIFT(SS), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .bright(bright), .en(en), .hCount(hCount), .vCount(vCount),
    .pos_x(pos_x), .pos_y(pos_y), .pos_load(pos_load), .blink_en(blink_en),
    .background(background), .rom_row(rom_row), .rom_col(rom_col), .rom_color(rom_color),
    .pos_pending(pos_pending), .rgb(rgb));

  initial clk = 0;
  always #5 clk = ~clk;

  // ROM with LAT-clock read latency serving the DUT
  always @(posedge clk) begin
    rp[0] <= rom[rom_row][rom_col];
    for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
  end
  assign rom_color = rp[LAT-1];

  function automatic bit vis_now();
`ifdef SPRITE_BLINK_EN
    return ((nfr / BF) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step(input int h, input int v, input bit br, input bit e, input logic [11:0] bg,
                      input bit ld, input int px, input int py, input bit r, input string tag);
    int hm, vm, dxi, dyi, er, ec;
    bit ht, fs;
    logic [11:0] ex, rv, got;
    hm = h & 1023;
    vm = v & 1023;
    hCount = 10'(hm); vCount = 10'(vm); bright = br; en = e; background = bg;
    pos_load = ld; pos_x = 10'(px); pos_y = 10'(py); rst = r;
    dxi = hm - cx;
    dyi = vm - cy;
    ht = e && vis_now() && dxi >= 0 && dyi >= 0 && dxi < (SW << SS) && dyi < (SH << SS);
    er = ht ? dyi / (1 << SS) : 0;
    ec = ht ? dxi / (1 << SS) : 0;
    rv = rom[er][ec];
    ex = !br ? 12'h000 : (ht && rv != 12'hFFF) ? rv : bg;
    q.push_back(ex);
    @(negedge clk);
    if (ready) begin
      if (q.size() > LAT) begin
        got = q.pop_front();
        checks++;
        if (rgb !== got) begin
          errors++;
          $display("FAIL %s rgb got %h expected %h", tag, rgb, got);
        end
      end
      checks++;
      if (rom_row !== 4'(er) || rom_col !== 8'(ec)) begin
        errors++;
        $display("FAIL %s rom_addr got row %0d col %0d expected row %0d col %0d", tag, rom_row, rom_col, er, ec);
      end
      checks++;
      if (pos_pending !== pend) begin
        errors++;
        $display("FAIL %s pos_pending got %b expected %b", tag, pos_pending, pend);
      end
    end
    @(posedge clk);
    #1;
    fs = hm == 0 && vm == 0;
    if (r) begin
      cx = 375; cy = 145; sx = 375; sy = 145; pend = 0; nfr = 0;
      q.delete();
      repeat (LAT) q.push_back(12'h000);
      ready = 1;
    end else begin
      if (fs && pend) begin cx = sx; cy = sy; pend = 0; end
      if (ld) begin sx = px; sy = py; pend = 1; end
      if (!blink_en) nfr = 0;
      else if (fs) nfr++;
    end
  endtask

  task automatic px(input int h, input int v, input string tag);
    step(h, v, 1, 1, 12'h123, 0, 0, 0, 0, tag);
  endtask

  task automatic test_reset();
    step(5, 5, 1, 1, 12'h456, 0, 0, 0, 1, "reset");
    step(5, 5, 1, 1, 12'h456, 0, 0, 0, 1, "reset");
    for (int i = 0; i < LAT + 1; i++) px(375, 145, "reset_flush");
  endtask

  task automatic test_basic();
    rom[0][0] = 12'h0F0;
    rom[0][1] = 12'hFFF;
    px(375, 145, "basic_origin");
    px(376, 145, "basic_rep");
    px(377, 145, "basic_key");
    px(378, 146, "basic_key_row");
    px(674, 166, "basic_last");
    px(675, 145, "basic_right_out");
    px(374, 145, "basic_left_out");
    px(400, 167, "basic_below");
    step(380, 150, 0, 1, 12'h123, 0, 0, 0, 0, "basic_dark");
    step(380, 150, 1, 0, 12'h321, 0, 0, 0, 0, "basic_disabled");
  endtask

  task automatic test_move();
    step(10, 300, 1, 1, 12'h123, 1, 100, 200, 0, "move_load");
    px(375, 145, "move_old_pos");
    px(100, 200, "move_new_early");
    px(0, 0, "move_fs");
    px(100, 200, "move_new");
    px(375, 145, "move_old_gone");
    step(0, 0, 1, 1, 12'h123, 1, 375, 145, 0, "move_load_fs");
    px(100, 200, "move_fs_staged");
    px(0, 0, "move_fs2");
    px(375, 145, "move_back");
  endtask

  task automatic test_clip();
    step(10, 10, 1, 1, 12'h123, 1, 600, 145, 0, "clip_load");
    px(0, 0, "clip_fs");
    for (int h = 600; h < 640; h++) px(h, 145, "clip_visible");
    for (int h = 0; h < 110; h += 5) px(h, 145, "clip_nowrap");
  endtask

  task automatic test_random();
    int h, v, ppx, ppy;
    bit ld, fs, r;
    for (int i = 0; i < 3000; i++) begin
      fs = $urandom_range(0, 39) == 0;
      h = fs ? 0 : cx + $urandom_range(0, 340) - 20;
      v = fs ? 0 : cy + $urandom_range(0, 30) - 4;
      ld = !fs && $urandom_range(0, 29) == 0;
      ppx = $urandom_range(0, 700);
      ppy = $urandom_range(0, 470);
      r = $urandom_range(0, 399) == 0;
      if ($urandom_range(0, 199) == 0) blink_en = ~blink_en;
      step(h, v, $urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0, 12'($urandom),
           ld, ppx, ppy, r, "random");
    end
  endtask

  task automatic test_blink();
    blink_en = 1;
    step(1, 1, 1, 1, 12'h123, 0, 0, 0, 1, "blink_reset");
    for (int f = 0; f < 6; f++) begin
      px(380, 150, "blink_frame");
      if (f == 3) begin
        step(1, 1, 1, 1, 12'h123, 0, 0, 0, 1, "blink_rst");
        px(380, 150, "blink_after_rst");
      end
      px(0, 0, "blink_fs");
    end
    blink_en = 0;
    px(380, 150, "blink_off");
    px(380, 150, "blink_off2");
  endtask

  initial begin
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 256; c++)
        rom[r][c] = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
    blink_en = 0;
    test_reset();
    test_basic();
    test_move();
    test_clip();
`ifdef SPRITE_BLINK_EN
    test_blink();
`endif
    test_random();
    for (int i = 0; i < LAT; i++) px(0, 479, "drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
